pattern_gen: RTL and testbench

- Parametrised, registered successor to the combinational colour-band generator in the video pattern path.
- Sits between the timing generator (h_count/v_count/active) and the HDMI/VGA output stage.
- Produces one of several test patterns, selectable per frame, with optional per-frame horizontal scrolling.
- Fixed 2-cycle pipeline latency, with data-enable delayed to match.

---
 rtl/pg_pkg.sv | 18 +
 rtl/pg_color_lut.sv | 11 +
 rtl/pattern_gen.sv | 114 +++++++++++
 tb/tb_pattern_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pg_pkg.sv
// pg_pkg: shared mode encodings and colour indices for the pattern generator
package pg_pkg;
   typedef logic [2:0] color_t;
   localparam logic [2:0] PG_HBANDS  = 3'd0;
   localparam logic [2:0] PG_VBARS   = 3'd1;
   localparam logic [2:0] PG_CHECKER = 3'd2;
   localparam logic [2:0] PG_RAMP    = 3'd3;
   localparam logic [2:0] PG_SOLID   = 3'd4;
   // colour index bits are {r,g,b}; each set bit drives that component full scale
   localparam color_t BLACK   = 3'b000;
   localparam color_t BLUE    = 3'b001;
   localparam color_t GREEN   = 3'b010;
   localparam color_t CYAN    = 3'b011;
   localparam color_t RED     = 3'b100;
   localparam color_t MAGENTA = 3'b101;
   localparam color_t YELLOW  = 3'b110;
   localparam color_t WHITE   = 3'b111;
endpackage

// File: rtl/pg_color_lut.sv
// pg_color_lut: combinational colour index to {r,g,b} expansion
module pg_color_lut
   import pg_pkg::*;
#(
   parameter int CW = 8
) (
   input  color_t            idx,
   output logic [3*CW-1:0]   rgb
);
   assign rgb = {{CW{idx[2]}}, {CW{idx[1]}}, {CW{idx[0]}}};
endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: registered test-pattern generator with per-frame mode and horizontal scroll
module pattern_gen
   import pg_pkg::*;
#(
   parameter int H_ACTIVE    = 1920,
   parameter int V_ACTIVE    = 1080,
   parameter int CNT_W       = 12,
   parameter int CW          = 8,
   parameter int NUM_BANDS   = 4,
   parameter int CHK_LOG2    = 6,
   parameter int SCROLL_STEP = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [CNT_W-1:0]  h_count,
   input  logic [CNT_W-1:0]  v_count,
   input  logic              active,
   input  logic              frame_start,
   input  logic [2:0]        mode_sel,
   input  logic              scroll_en,
   input  logic [3*CW-1:0]   solid_rgb,
   output logic [CW-1:0]     read_r,
   output logic [CW-1:0]     read_g,
   output logic [CW-1:0]     read_b,
   output logic              de_out
);
   localparam int BAND_H = V_ACTIVE / NUM_BANDS;
   localparam int BAR_W  = H_ACTIVE / 8;
   localparam int BW     = NUM_BANDS > 4 ? $clog2(NUM_BANDS) : 2;
   localparam logic [CNT_W:0] H_FULL = (CNT_W+1)'(H_ACTIVE);
   localparam color_t BAND_SEQ [4] = '{RED, GREEN, BLUE, YELLOW};
   localparam color_t BAR_SEQ  [8] = '{WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK};

   logic [2:0]       mode_q, mode_eff;
   logic [CNT_W:0]   off_acc, off_cur, off_eff, off_sum, h_sum;
   logic             valid;
   logic [CNT_W:0]   s1_h;
   logic [CNT_W-1:0] s1_v;
   logic [2:0]       s1_mode;
   logic             s1_valid;
   logic [3*CW-1:0]  s1_rgb;
   logic [BW-1:0]    band;
   logic [2:0]       bar;
   color_t           idx;
   logic [3*CW-1:0]  lut_rgb, rgb_nxt;

   // off_acc advances at each frame_start; off_cur is the offset the current frame scrolls by
   assign off_sum  = off_acc + (CNT_W+1)'(SCROLL_STEP);
   assign mode_eff = frame_start ? mode_sel : mode_q;
   assign off_eff  = frame_start ? off_acc : off_cur;
   assign h_sum    = {1'b0, h_count} + off_eff;
   assign valid    = active && {1'b0, h_count} < H_FULL && {1'b0, v_count} < (CNT_W+1)'(V_ACTIVE);

   // frame-rate state: mode and scroll offset latched at each frame_start
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         mode_q  <= PG_HBANDS;
         off_acc <= '0;
         off_cur <= '0;
      end else if (frame_start) begin
         mode_q  <= mode_sel;
         off_cur <= off_acc;
         off_acc <= !scroll_en ? off_acc : off_sum >= H_FULL ? off_sum - H_FULL : off_sum;
      end

   // stage 1: wrap the scrolled column and capture the pixel context
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         s1_h     <= '0;
         s1_v     <= '0;
         s1_mode  <= '0;
         s1_valid <= 1'b0;
         s1_rgb   <= '0;
      end else begin
         s1_h     <= h_sum >= H_FULL ? h_sum - H_FULL : h_sum;
         s1_v     <= v_count;
         s1_mode  <= mode_eff;
         s1_valid <= valid;
         s1_rgb   <= solid_rgb;
      end

   // band and bar indices from ascending threshold chains; the last threshold passed wins
   always_comb begin
      band = '0;
      bar  = '0;
      for (int k = 1; k < NUM_BANDS; k++) band = s1_v >= CNT_W'(k * BAND_H) ? BW'(k) : band;
      for (int k = 1; k < 8; k++) bar = s1_h >= (CNT_W+1)'(k * BAR_W) ? 3'(k) : bar;
   end

   assign idx = s1_mode == PG_HBANDS  ? BAND_SEQ[band[1:0]] :
                s1_mode == PG_VBARS   ? BAR_SEQ[bar] :
                s1_mode == PG_CHECKER ? ((s1_h[CHK_LOG2] ^ s1_v[CHK_LOG2]) ? WHITE : BLACK) :
                BLACK;

   pg_color_lut #(.CW(CW)) u_lut (
      .idx (idx),
      .rgb (lut_rgb)
   );

   assign rgb_nxt = !s1_valid             ? '0 :
                    s1_mode == PG_RAMP    ? {3{s1_h[CW-1:0]}} :
                    s1_mode == PG_SOLID   ? s1_rgb :
                    lut_rgb;

   // stage 2: registered colour and matching data-enable
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         {read_r, read_g, read_b} <= '0;
         de_out <= 1'b0;
      end else begin
         {read_r, read_g, read_b} <= rgb_nxt;
         de_out <= s1_valid;
      end
endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed vectors against a frame-level behavioural model of pattern_gen
module tb_pattern_gen;
   localparam logic [23:0] BANDS [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00};
   localparam logic [23:0] BARS  [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic        clk = 0, reset_n = 1;
   logic [11:0] h_count = 0, v_count = 0;
   logic        active = 0, frame_start = 0, scroll_en = 0;
   logic [2:0]  mode_sel = 0;
   logic [23:0] solid_rgb = 0;
   logic [7:0]  read_r, read_g, read_b;
   logic        de_out;
   logic        lit_on = 0;
   logic [24:0] lit_val = 0;
   int          lit_id = 0;
   logic        chk_en = 0;
   int          vectors = 0, miscompares = 0;

   logic [2:0]  m_mode;
   int          m_acc, m_off;
   logic [24:0] e1, e2, l1_val, l2_val;
   logic        l1_on, l2_on;
   int          l1_id, l2_id;

   always #5 clk = ~clk;

   pattern_gen dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .h_count     (h_count),
      .v_count     (v_count),
      .active      (active),
      .frame_start (frame_start),
      .mode_sel    (mode_sel),
      .scroll_en   (scroll_en),
      .solid_rgb   (solid_rgb),
      .read_r      (read_r),
      .read_g      (read_g),
      .read_b      (read_b),
      .de_out      (de_out)
   );

   function automatic logic [24:0] pixel(input int h, input int v, input logic a,
                                         input logic [2:0] m, input int off, input logic [23:0] solid);
      int he;
      if (!a || h >= 1920 || v >= 1080) return 25'h0;
      he = (h + off) % 1920;
      case (m)
         3'd0: return {1'b1, BANDS[(v / 270) % 4]};
         3'd1: return {1'b1, BARS[he / 240]};
         3'd2: return {1'b1, ((((he >> 6) ^ (v >> 6)) & 1) != 0) ? 24'hFFFFFF : 24'h000000};
         3'd3: return {1'b1, {3{8'(he % 256)}}};
         3'd4: return {1'b1, solid};
         default: return {1'b1, 24'h000000};
      endcase
   endfunction

   // model: each frame uses the mode sampled at its frame_start and the offset accumulated before it
   always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         m_mode <= 0; m_acc <= 0; m_off <= 0;
         e1 <= 0; e2 <= 0;
         l1_on <= 0; l2_on <= 0; l1_val <= 0; l2_val <= 0; l1_id <= 0; l2_id <= 0;
      end else begin
         e1 <= pixel(int'(h_count), int'(v_count), active, frame_start ? mode_sel : m_mode,
                     frame_start ? m_acc : m_off, solid_rgb);
         e2 <= e1;
         l1_on <= lit_on; l1_val <= lit_val; l1_id <= lit_id;
         l2_on <= l1_on;  l2_val <= l1_val;  l2_id <= l1_id;
         if (frame_start) begin
            m_mode <= mode_sel;
            m_off  <= m_acc;
            if (scroll_en) m_acc <= (m_acc + 4) % 1920;
         end
      end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         vectors++;
         if ({de_out, read_r, read_g, read_b} !== e2) begin
            miscompares++;
            $display("FAIL model t=%0t: dut %h, model %h", $time, {de_out, read_r, read_g, read_b}, e2);
         end
         if (l2_on) begin
            vectors++;
            if ({de_out, read_r, read_g, read_b} !== l2_val) begin
               miscompares++;
               $display("FAIL lit%0d t=%0t: dut %h, expected %h", l2_id, $time, {de_out, read_r, read_g, read_b}, l2_val);
            end
         end
         if (!reset_n) begin
            vectors++;
            if ({de_out, read_r, read_g, read_b} !== 25'h0) begin
               miscompares++;
               $display("FAIL reset_zero t=%0t: dut %h, expected 0", $time, {de_out, read_r, read_g, read_b});
            end
         end
      end
   end

   task automatic px(input int h, input int v, input logic a, input logic fs, input logic [2:0] ms,
                     input logic se, input logic lo = 1'b0, input logic [24:0] lv = 25'h0);
      @(posedge clk);
      #2;
      h_count = 12'(h); v_count = 12'(v); active = a; frame_start = fs;
      mode_sel = ms; scroll_en = se; lit_on = lo; lit_val = lv; lit_id++;
   endtask

   int          band_v   [8] = '{0, 269, 270, 539, 540, 809, 810, 1079};
   logic [23:0] band_c   [8] = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'h00FF00,
                                 24'h0000FF, 24'h0000FF, 24'hFFFF00, 24'hFFFF00};
   int          bar_h    [4] = '{0, 239, 240, 1919};
   logic [23:0] bar_c    [4] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h000000};

   initial begin
      #1 reset_n = 0;
      #2 chk_en = 1;
      repeat (3) @(posedge clk);
      #2 reset_n = 1;
      for (int i = 0; i < 8; i++) px(100, band_v[i], 1, i == 0, 3'd0, 0, 1, {1'b1, band_c[i]});
      for (int i = 0; i < 4; i++) px(bar_h[i], 0, 1, i == 0, 3'd1, 0, 1, {1'b1, bar_c[i]});
      px(1920, 0, 1, 0, 3'd1, 0, 1, 25'h0);
      px(10, 5, 1, 1, 3'd3, 1, 1, {1'b1, 24'h0A0A0A});
      px(10, 5, 1, 1, 3'd3, 1, 1, {1'b1, 24'h0E0E0E});
      px(10, 5, 1, 1, 3'd3, 1, 1, {1'b1, 24'h121212});
      for (int i = 0; i < 476; i++) px(0, 0, 0, 1, 3'd3, 1);
      px(10, 5, 1, 1, 3'd3, 1, 1, {1'b1, 24'h060606});
      px(3, 5, 1, 0, 3'd3, 0, 1, {1'b1, 24'h7F7F7F});
      px(4, 5, 1, 0, 3'd3, 0, 1, {1'b1, 24'h000000});
      px(10, 5, 1, 1, 3'd3, 0, 1, {1'b1, 24'h0A0A0A});
      px(100, 300, 1, 1, 3'd0, 0, 1, {1'b1, 24'h00FF00});
      px(100, 300, 1, 0, 3'd2, 0, 1, {1'b1, 24'h00FF00});
      px(101, 300, 1, 0, 3'd2, 0, 1, {1'b1, 24'h00FF00});
      px(64, 0, 1, 1, 3'd2, 0, 1, {1'b1, 24'hFFFFFF});
      px(0, 0, 1, 0, 3'd2, 0, 1, {1'b1, 24'h000000});
      px(64, 64, 1, 0, 3'd2, 0, 1, {1'b1, 24'h000000});
      px(0, 64, 1, 0, 3'd0, 0, 1, {1'b1, 24'hFFFFFF});
      solid_rgb = 24'h123456;
      px(5, 5, 1, 1, 3'd4, 0, 1, {1'b1, 24'h123456});
      px(6, 5, 1, 0, 3'd4, 0, 1, {1'b1, 24'h123456});
      px(7, 5, 1, 0, 3'd4, 0);
      @(posedge clk);
      #2 reset_n = 0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1;
      px(100, 0, 1, 0, 3'd4, 0, 1, {1'b1, 24'hFF0000});
      px(100, 270, 1, 0, 3'd4, 0, 1, {1'b1, 24'h00FF00});
      px(100, 0, 0, 0, 3'd4, 0, 1, 25'h0);
      px(100, 1080, 1, 0, 3'd0, 0, 1, 25'h0);
      px(0, 0, 0, 1, 3'd1, 0, 1, 25'h0);
      px(0, 0, 1, 0, 3'd1, 0, 1, {1'b1, 24'hFFFFFF});
      repeat (3) px(0, 0, 0, 0, 3'd0, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
